// File: rtl/eda_flag_serializer.sv
// Serializes a row of regional-maxima flags into binary column indices,
// lowest column first, with valid/ready handshakes on both sides.
module eda_flag_serializer #(
  parameter int FLAG_WIDTH = 8,
  parameter int COL_WIDTH  = 3,
  parameter int ROW_WIDTH  = 4,
  parameter int CNT_WIDTH  = $clog2(FLAG_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flag_valid,
  output logic                  flag_ready,
  input  logic [FLAG_WIDTH-1:0] flag_vector,
  input  logic [ROW_WIDTH-1:0]  flag_row,
  output logic                  idx_valid,
  input  logic                  idx_ready,
  output logic [COL_WIDTH-1:0]  idx_col,
  output logic [ROW_WIDTH-1:0]  idx_row,
  output logic                  idx_last,
  output logic                  vec_done,
  output logic [CNT_WIDTH-1:0]  vec_count
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [FLAG_WIDTH-1:0] ONE = FLAG_WIDTH'(1);

  state_t                r_state, w_nextState;
  logic [FLAG_WIDTH-1:0] r_pend;
  logic [ROW_WIDTH-1:0]  r_row;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_vecDone;
  logic [CNT_WIDTH-1:0]  r_vecCount;
  logic                  r_zeroDefer;

  logic [FLAG_WIDTH-1:0] w_onehot;
  logic [FLAG_WIDTH-1:0] w_rest;
  logic [COL_WIDTH-1:0]  w_col;
  logic                  w_idxFire, w_lastFire;
  logic                  w_accept, w_acceptNz, w_acceptZero;
  logic                  w_doneNext, w_deferNext;
  logic [CNT_WIDTH-1:0]  w_countNext;

  assign w_onehot = r_pend & (~r_pend + ONE);
  assign w_rest   = r_pend & (r_pend - ONE);

  always_comb begin
    w_col = '0;
    for (int i = 0; i < FLAG_WIDTH; i++) begin
      if (w_onehot[i]) w_col = w_col | COL_WIDTH'(i);
    end
  end

  assign idx_valid    = (r_state == SCAN);
  assign idx_last     = idx_valid && (w_rest == '0);
  assign idx_col      = w_col;
  assign idx_row      = r_row;
  assign w_idxFire    = idx_valid && idx_ready;
  assign w_lastFire   = w_idxFire && idx_last;
  assign flag_ready   = (r_state == IDLE) || w_lastFire;
  assign w_accept     = flag_valid && flag_ready;
  assign w_acceptNz   = w_accept && (|flag_vector);
  assign w_acceptZero = w_accept && !(|flag_vector);
  assign vec_done     = r_vecDone;
  assign vec_count    = r_vecCount;

  always_comb begin
    w_nextState = r_state;
    if (w_acceptNz) w_nextState = SCAN;
    else if (w_lastFire) w_nextState = IDLE;
  end

  // A zero vector accepted alongside a final handshake has its done pulse
  // deferred by one cycle so both completions are reported.
  always_comb begin
    w_doneNext  = 1'b0;
    w_countNext = r_vecCount;
    w_deferNext = r_zeroDefer;
    if (w_lastFire) begin
      w_doneNext  = 1'b1;
      w_countNext = r_cnt + CNT_WIDTH'(1);
      w_deferNext = r_zeroDefer || w_acceptZero;
    end else if (r_zeroDefer) begin
      w_doneNext  = 1'b1;
      w_countNext = '0;
      w_deferNext = w_acceptZero;
    end else if (w_acceptZero) begin
      w_doneNext  = 1'b1;
      w_countNext = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_row       <= '0;
      r_cnt       <= '0;
      r_vecDone   <= 1'b0;
      r_vecCount  <= '0;
      r_zeroDefer <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_vecDone   <= w_doneNext;
      r_vecCount  <= w_countNext;
      r_zeroDefer <= w_deferNext;
      if (w_acceptNz) begin
        r_pend <= flag_vector;
        r_row  <= flag_row;
        r_cnt  <= '0;
      end else if (w_idxFire) begin
        r_pend <= r_pend & ~w_onehot;
        r_cnt  <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_eda_flag_serializer.sv
// Directed bench for eda_flag_serializer with a queue-based reference model
// checked every cycle, plus hand-computed spot checks.
module tb_eda_flag_serializer;

  localparam int FLAG_WIDTH = 8;
  localparam int COL_WIDTH  = 3;
  localparam int ROW_WIDTH  = 4;
  localparam int CNT_WIDTH  = $clog2(FLAG_WIDTH + 1);

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  flag_valid;
  logic                  flag_ready;
  logic [FLAG_WIDTH-1:0] flag_vector;
  logic [ROW_WIDTH-1:0]  flag_row;
  logic                  idx_valid;
  logic                  idx_ready;
  logic [COL_WIDTH-1:0]  idx_col;
  logic [ROW_WIDTH-1:0]  idx_row;
  logic                  idx_last;
  logic                  vec_done;
  logic [CNT_WIDTH-1:0]  vec_count;

  int numVectors = 0;
  int numMiscompares = 0;

  eda_flag_serializer #(
    .FLAG_WIDTH(FLAG_WIDTH), .COL_WIDTH(COL_WIDTH),
    .ROW_WIDTH(ROW_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .flag_valid(flag_valid), .flag_ready(flag_ready),
    .flag_vector(flag_vector), .flag_row(flag_row),
    .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx_col(idx_col), .idx_row(idx_row), .idx_last(idx_last),
    .vec_done(vec_done), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // Model: columns still to emit for the current vector, and completion
  // counts waiting to be reported one per cycle.
  int colQ[$];
  int doneQ[$];
  int mRow;
  int mCnt;
  bit mDone;
  int mDoneCount;

  task automatic checkOutput(input string name, input int actual, input int expected);
    numVectors++;
    if (actual != expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      colQ.delete();
      doneQ.delete();
      mRow = 0;
      mCnt = 0;
      mDone = 1'b0;
      mDoneCount = 0;
    end else begin
      bit valid, last, ready;
      valid = colQ.size() > 0;
      last  = colQ.size() == 1;
      ready = !valid || (idx_ready && last);
      if (valid && idx_ready) begin
        void'(colQ.pop_front());
        mCnt++;
        if (last) doneQ.push_back(mCnt);
      end
      if (flag_valid && ready) begin
        if (flag_vector != '0) begin
          for (int i = 0; i < FLAG_WIDTH; i++)
            if (flag_vector[i]) colQ.push_back(i);
          mRow = int'(flag_row);
          mCnt = 0;
        end else begin
          doneQ.push_back(0);
        end
      end
      if (doneQ.size() > 0) begin
        mDone = 1'b1;
        mDoneCount = doneQ.pop_front();
      end else begin
        mDone = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit valid, last;
    valid = colQ.size() > 0;
    last  = colQ.size() == 1;
    checkOutput("model idx_valid", int'(idx_valid), int'(valid));
    if (valid && idx_valid) begin
      checkOutput("model idx_col", int'(idx_col), colQ[0]);
      checkOutput("model idx_row", int'(idx_row), mRow);
      checkOutput("model idx_last", int'(idx_last), int'(last));
    end
    checkOutput("model flag_ready", int'(flag_ready), int'(!valid || (idx_ready && last)));
    checkOutput("model vec_done", int'(vec_done), int'(mDone));
    if (mDone) checkOutput("model vec_count", int'(vec_count), mDoneCount);
  end

  task automatic applyStimulus(input bit valid, input logic [FLAG_WIDTH-1:0] vec,
                               input logic [ROW_WIDTH-1:0] row, input bit rdy);
    flag_valid  = valid;
    flag_vector = vec;
    flag_row    = row;
    idx_ready   = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nextCol;
    bit seenDone;
    reset_n = 1'b0;
    applyStimulus(1'b1, 8'hFF, 4'd3, 1'b1);
    step();
    step();
    checkOutput("reset idx_valid", int'(idx_valid), 0);
    checkOutput("reset idx_last", int'(idx_last), 0);
    checkOutput("reset idx_col", int'(idx_col), 0);
    checkOutput("reset idx_row", int'(idx_row), 0);
    checkOutput("reset flag_ready", int'(flag_ready), 1);
    checkOutput("reset vec_done", int'(vec_done), 0);
    checkOutput("reset vec_count", int'(vec_count), 0);
    applyStimulus(1'b0, '0, '0, 1'b1);
    reset_n = 1'b1;
    step();
    checkOutput("post-reset idx_valid", int'(idx_valid), 0);

    // Basic three-flag vector.
    applyStimulus(1'b1, 8'b1010_0100, 4'd5, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("t1 col0", int'(idx_col), 2);
    checkOutput("t1 row", int'(idx_row), 5);
    checkOutput("t1 last0", int'(idx_last), 0);
    step();
    checkOutput("t1 col1", int'(idx_col), 5);
    step();
    checkOutput("t1 col2", int'(idx_col), 7);
    checkOutput("t1 last2", int'(idx_last), 1);
    step();
    checkOutput("t1 done", int'(vec_done), 1);
    checkOutput("t1 count", int'(vec_count), 3);
    checkOutput("t1 idle", int'(idx_valid), 0);
    step();

    // All-zero vector.
    applyStimulus(1'b1, 8'h00, 4'd3, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("t2 done", int'(vec_done), 1);
    checkOutput("t2 count", int'(vec_count), 0);
    checkOutput("t2 valid", int'(idx_valid), 0);
    checkOutput("t2 ready", int'(flag_ready), 1);
    step();
    checkOutput("t2 done clear", int'(vec_done), 0);

    // Full vector with toggling downstream ready.
    applyStimulus(1'b1, 8'hFF, 4'd7, 1'b1);
    step();
    flag_valid = 1'b0;
    nextCol = 0;
    seenDone = 1'b0;
    for (int c = 0; c < 30 && !seenDone; c++) begin
      idx_ready = (c % 2 == 0);
      if (idx_valid && idx_ready) begin
        checkOutput("t3 col", int'(idx_col), nextCol);
        nextCol++;
      end
      step();
      if (vec_done) begin
        seenDone = 1'b1;
        checkOutput("t3 count", int'(vec_count), 8);
      end
    end
    checkOutput("t3 done seen", int'(seenDone), 1);
    checkOutput("t3 cols emitted", nextCol, 8);
    idx_ready = 1'b1;
    step();

    // Back-to-back vectors with no bubble.
    applyStimulus(1'b1, 8'b0000_0011, 4'd1, 1'b1);
    step();
    checkOutput("t4 col0", int'(idx_col), 0);
    checkOutput("t4 row0", int'(idx_row), 1);
    applyStimulus(1'b1, 8'b1000_0000, 4'd2, 1'b1);
    step();
    checkOutput("t4 col1", int'(idx_col), 1);
    checkOutput("t4 row1", int'(idx_row), 1);
    checkOutput("t4 ready", int'(flag_ready), 1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("t4 col2", int'(idx_col), 7);
    checkOutput("t4 row2", int'(idx_row), 2);
    checkOutput("t4 doneA", int'(vec_done), 1);
    checkOutput("t4 countA", int'(vec_count), 2);
    step();
    checkOutput("t4 doneB", int'(vec_done), 1);
    checkOutput("t4 countB", int'(vec_count), 1);
    step();

    // Single flags at both ends.
    applyStimulus(1'b1, 8'h01, 4'd6, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("t5 lo col", int'(idx_col), 0);
    checkOutput("t5 lo last", int'(idx_last), 1);
    checkOutput("t5 lo ready", int'(flag_ready), 1);
    step();
    checkOutput("t5 lo count", int'(vec_count), 1);
    applyStimulus(1'b1, 8'h80, 4'd9, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("t5 hi col", int'(idx_col), 7);
    checkOutput("t5 hi last", int'(idx_last), 1);
    checkOutput("t5 hi ready", int'(flag_ready), 1);
    step();
    step();

    // Final index followed by two zero vectors held back-to-back.
    applyStimulus(1'b1, 8'h01, 4'd3, 1'b1);
    step();
    applyStimulus(1'b1, 8'h00, 4'd0, 1'b1);
    step();
    checkOutput("t6 done1", int'(vec_done), 1);
    checkOutput("t6 count1", int'(vec_count), 1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("t6 zero done", int'(vec_done), 1);
    checkOutput("t6 zero count", int'(vec_count), 0);
    step();
    checkOutput("t6 zero done2", int'(vec_done), 1);
    step();
    checkOutput("t6 quiet", int'(vec_done), 0);

    // Reset in the middle of a scan.
    applyStimulus(1'b1, 8'hF0, 4'd9, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("t7 col4", int'(idx_col), 4);
    step();
    checkOutput("t7 col5", int'(idx_col), 5);
    step();
    checkOutput("t7 col6", int'(idx_col), 6);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t7 rst valid", int'(idx_valid), 0);
    checkOutput("t7 rst col", int'(idx_col), 0);
    checkOutput("t7 rst row", int'(idx_row), 0);
    checkOutput("t7 rst last", int'(idx_last), 0);
    checkOutput("t7 rst ready", int'(flag_ready), 1);
    checkOutput("t7 rst done", int'(vec_done), 0);
    checkOutput("t7 rst count", int'(vec_count), 0);
    step();
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checkOutput("t7 no stale idx", int'(idx_valid), 0);
      checkOutput("t7 no stale done", int'(vec_done), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule

// File: doc/eda_flag_serializer.md
# eda_flag_serializer

Serializes an N-bit regional-maxima flag vector into a stream of binary column indices, lowest index first. Each accepted vector is held in a pending register. Every cycle, the lowest set bit is isolated to a one-hot word and encoded to binary, and the result is emitted with a valid/ready handshake until no bits remain. The block sits between the per-row maxima-flag generator and the downstream coordinate writer, and is the sequential wrapper around the one-hot-to-binary encoding path.

## Interface
- FLAG_WIDTH, `CFG_N: flags per vector (columns per row).
- COL_WIDTH, `CFG_J_WIDTH: width of the binary column index.
- ROW_WIDTH, `CFG_I_WIDTH: width of the row tag carried with each vector.
- CNT_WIDTH, $clog2(FLAG_WIDTH+1): width of the per-vector index count.
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flag_valid  input  1  flag_vector/flag_row are valid.
- flag_ready  output  1  block accepts a vector this cycle.
- flag_vector  input  FLAG_WIDTH  maxima flags; bit i means column i.
- flag_row  input  ROW_WIDTH  row tag for the vector.
- idx_valid  output  1  idx_col/idx_row/idx_last are valid.
- idx_ready  input  1  downstream accepts the index.
- idx_col  output  COL_WIDTH  column index of the lowest pending flag.
- idx_row  output  ROW_WIDTH  row tag of the vector being serialized.
- idx_last  output  1  current index is the final one of its vector.
- vec_done  output  1  one-cycle pulse: a vector has been fully consumed.
- vec_count  output  CNT_WIDTH  number of indices emitted for that vector; valid with vec_done.

## Operation
- The FSM has two states: IDLE and SCAN. A pending register `pend` (FLAG_WIDTH) holds the bits not yet emitted. A row register holds the tag. A count register `cnt` (CNT_WIDTH) counts emitted indices.
- Accept occurs when flag_valid && flag_ready.
- flag_ready = (state==IDLE) || (idx_valid && idx_ready && idx_last). Because of the second term, flag_ready is combinational from idx_ready.
- On accept of a nonzero vector:
  - pend <= flag_vector, row <= flag_row, cnt <= 0, state <= SCAN.
- On accept of an all-zero vector:
  - State stays IDLE and no index is emitted.
  - vec_done pulses on the next cycle with vec_count = 0.
- In SCAN:
  - idx_valid = 1.
  - onehot = pend & (~pend + 1), i.e. the lowest set bit.
  - idx_col = binary encoding of onehot.
  - idx_last = (pend & (pend - 1)) == 0.
  - idx_row = row register.
- On an index handshake (idx_valid && idx_ready):
  - pend <= pend & ~onehot, cnt <= cnt + 1.
  - If idx_last, vec_count <= cnt + 1 and vec_done pulses on the next cycle.
  - If idx_last and no simultaneous accept, state <= IDLE.
  - If idx_last with a simultaneous accept, the new vector loads per the accept rules above. This gives zero-bubble back-to-back vectors.
- While idx_valid && !idx_ready, idx_col, idx_row and idx_last are held stable.
- Arithmetic: cnt never exceeds FLAG_WIDTH, so it does not wrap. idx_col zero-extends or truncates the encoded index to COL_WIDTH. FLAG_WIDTH <= 2^COL_WIDTH is required.

## Timing
- Reset values:
  - state = IDLE, pend = 0, row = 0, cnt = 0.
  - idx_valid = 0, idx_col = 0, idx_row = 0, idx_last = 0.
  - vec_done = 0, vec_count = 0.
  - flag_ready = 1. Transfers presented while reset_n is low are ignored.
- Latency: a vector accepted at edge t presents its first index at t+1.
- Throughput: with idx_ready held high, one index per cycle. A vector with k set bits occupies k cycles.
- vec_done is registered. It asserts exactly one cycle after the final handshake, or one cycle after accepting a zero vector.
- Back-to-back: the last index of vector A and the accept of vector B in the same cycle give, next cycle, idx_valid for B's first index and vec_done for A with A's count.
- Reset asserted mid-SCAN: the pending vector is discarded immediately, and no vec_done is generated for it.

## Test plan
- N=8, accept 8'b1010_0100 with row 5, idx_ready=1:
  - Indices 2, 5, 7 appear on consecutive cycles, starting the cycle after accept.
  - idx_row=5 throughout; idx_last only on 7.
  - vec_done with vec_count=3 on the cycle after index 7.
- Accept 8'h00:
  - No idx_valid.
  - vec_done with vec_count=0 one cycle later; flag_ready stays 1.
- Accept 8'hFF with idx_ready toggling 1,0,1,0…:
  - Indices 0 through 7 in order, each held stable while idx_ready=0.
  - vec_count=8.
- Back-to-back: hold flag_valid high with 8'b0000_0011 (row 1), then 8'b1000_0000 (row 2):
  - Index stream is 0, 1, 7 with no bubble.
  - Row tags are 1, 1, 2.
  - vec_done pulses twice, with counts 2 then 1.
- Single flag at bit 0 and at bit 7:
  - idx_last=1 on the first and only index.
  - flag_ready=1 in the same cycle as the handshake.
- Assert reset_n=0 mid-SCAN of 8'hF0 after two indices:
  - All outputs go to their reset values asynchronously.
  - After release, no stale index and no vec_done for 8'hF0.
